// File: rtl/dma_multi_channel.sv
// rtl/dma_multi_channel.sv - multi-channel cycle-stealing memory-to-memory DMA engine
module dma_multi_channel #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done,
  input  logic              mem_free,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do
);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, WRITE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q [NUM_CH];
  logic [ADDR_W-1:0] dst_q [NUM_CH];
  logic [LEN_W-1:0]  len_q [NUM_CH];
  logic [CH_W-1:0]   sel, ptr, ptr_nxt, pick;
  logic              pick_vld;
  logic [DATA_W-1:0] data_q;
  logic              cfg_ch_ok, cfg_fire, word_done;

  // Channel indices beyond NUM_CH (non power-of-two counts) are never accepted.
  assign cfg_ch_ok = int'(cfg_ch) < NUM_CH;
  assign cfg_ready = cfg_ch_ok && !busy[cfg_ch];
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign word_done = (state == WRITE) && mem_free;
  assign ptr_nxt   = (int'(sel) == NUM_CH - 1) ? '0 : sel + CH_W'(1);

  // Round-robin: first busy channel at or after ptr, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      int              j;
      logic [CH_W-1:0] jj;
      j = int'(ptr) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      jj = j[CH_W-1:0];
      if (!pick_vld && busy[jj]) begin
        pick_vld = 1'b1;
        pick     = jj;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_di    = '0;
    case (state)
      IDLE: if (pick_vld) state_nxt = READ;
      READ: begin
        mem_req  = mem_free;
        mem_addr = src_q[sel];
        if (mem_free) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = WRITE;
      WRITE: begin
        mem_req  = mem_free;
        mem_we   = mem_free;
        mem_addr = dst_q[sel];
        mem_di   = data_q;
        if (mem_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sel    <= '0;
      ptr    <= '0;
      data_q <= '0;
      busy   <= '0;
      done   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      done  <= '0;
      if (state == IDLE && pick_vld) sel <= pick;
      if (state == CAPTURE) data_q <= mem_do;
      if (word_done) begin
        src_q[sel] <= src_q[sel] + ADDR_W'(1);
        dst_q[sel] <= dst_q[sel] + ADDR_W'(1);
        len_q[sel] <= len_q[sel] - LEN_W'(1);
        ptr        <= ptr_nxt;
        if (len_q[sel] == LEN_W'(1)) begin
          busy[sel] <= 1'b0;
          done[sel] <= 1'b1;
        end
      end
      // A configurable channel is idle, so it never collides with sel above.
      if (cfg_fire) begin
        src_q[cfg_ch] <= cfg_src;
        dst_q[cfg_ch] <= cfg_dst;
        len_q[cfg_ch] <= cfg_len;
        busy[cfg_ch]  <= (cfg_len != '0);
        done[cfg_ch]  <= (cfg_len == '0);
      end
    end
  end

endmodule

// File: tb/tb_dma_multi_channel.sv
// tb/tb_dma_multi_channel.sv - self-checking bench for dma_multi_channel
module tb_dma_multi_channel;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [ADDR_W-1:0] cfg_src, cfg_dst;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_ready;
  logic [NUM_CH-1:0] busy, done;
  logic              mem_free, mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_di;
  logic [DATA_W-1:0] mem_do = '0;

  dma_multi_channel #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_ready(cfg_ready), .busy(busy), .done(done),
    .mem_free(mem_free), .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // SRAM model: unwritten words read back a fixed address-derived pattern.
  logic [DATA_W-1:0] mem [0:65535];
  bit                written [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];
  logic [ADDR_W-1:0] rd_log [0:1023];
  logic [ADDR_W-1:0] wr_log [0:1023];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int viol = 0;
  int done_cnt [NUM_CH] = '{default: 0};

  function automatic logic [31:0] seed_val(input logic [15:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return written[a] ? mem[a] : seed_val(a);
  endfunction

  always @(negedge clk) begin
    if ((mem_req && !mem_free) || (mem_we && !mem_req)) viol <= viol + 1;
    if (mem_req && mem_we) begin
      mem[mem_addr]          <= mem_di;
      written[mem_addr]      <= 1'b1;
      wr_log[wr_cnt % 1024]  <= mem_addr;
      wr_cnt                 <= wr_cnt + 1;
    end else if (mem_req) begin
      mem_do                 <= mem_val(mem_addr);
      rd_log[rd_cnt % 1024]  <= mem_addr;
      rd_cnt                 <= rd_cnt + 1;
    end
    for (int c = 0; c < NUM_CH; c++) if (done[c]) done_cnt[c] <= done_cnt[c] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_copy(input logic [15:0] s, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) ref_mem[16'(int'(d) + i)] = ref_mem[16'(int'(s) + i)];
  endtask

  task automatic check_data(input string nm, input logic [15:0] d, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++)
      if (mem_val(16'(int'(d) + i)) !== ref_mem[16'(int'(d) + i)]) bad++;
    check({nm, " data"}, bad, 0);
  endtask

  // Cycle-level timing from the protocol rules: per word one idle cycle, a read
  // that waits for a free cycle, one capture cycle, a write that waits likewise.
  function automatic int model_latency(input int n, input logic [3:0] pat);
    int c;
    c = 0;
    for (int w = 0; w < n; w++) begin
      c++;
      while (!pat[c % 4]) c++;
      c += 2;
      while (!pat[c % 4]) c++;
      c++;
    end
    return c;
  endfunction

  task automatic run_single(input string nm, input int ch, input logic [15:0] s, input logic [15:0] d,
                            input int n, input logic [3:0] pat, input int exp_lat, input int intrude);
    int rd0, wr0, dn0, v0, t, lat, bad;
    logic [CH_W-1:0] chv;
    chv = CH_W'(ch);
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt[ch]; v0 = viol;
    cfg_valid = 1'b1; cfg_ch = chv; cfg_src = s; cfg_dst = d; cfg_len = LEN_W'(n); mem_free = 1'b1;
    #1 check({nm, " cfg_ready"}, cfg_ready, 1);
    tick();
    check({nm, " busy_after_cfg"}, busy[chv], (n != 0));
    t = 0; lat = -1;
    while (t < 400) begin
      if (t == intrude) begin
        cfg_valid = 1'b1; cfg_src = s ^ 16'h5555; cfg_dst = d ^ 16'h0F0F; cfg_len = 2;
        #1 check({nm, " cfg_ready_busy"}, cfg_ready, 0);
      end else cfg_valid = 1'b0;
      mem_free = pat[t % 4];
      if (done[chv]) begin
        lat = t;
        break;
      end
      tick();
      t++;
    end
    cfg_valid = 1'b0;
    check({nm, " latency"}, lat, exp_lat);
    check({nm, " busy_at_done"}, busy[chv], 0);
    mem_free = 1'b1;
    tick();
    check({nm, " done_width"}, done[chv], 0);
    check({nm, " done_count"}, done_cnt[ch] - dn0, 1);
    check({nm, " reads"}, rd_cnt - rd0, n);
    check({nm, " writes"}, wr_cnt - wr0, n);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (rd_log[(rd0 + i) % 1024] !== 16'(int'(s) + i)) bad++;
      if (wr_log[(wr0 + i) % 1024] !== 16'(int'(d) + i)) bad++;
    end
    check({nm, " addr_seq"}, bad, 0);
    check({nm, " req_when_busy"}, viol - v0, 0);
    ref_copy(s, d, n);
    check_data(nm, d, n);
  endtask

  typedef struct {
    int          ch;
    logic [15:0] src;
    logic [15:0] dst;
    int          len;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = seed_val(16'(i));
    reset = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_src = '0; cfg_dst = '0; cfg_len = '0; mem_free = 1'b1;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset cfg_ready", cfg_ready, 1);
    reset = 1'b0;
    tick();

    vecs[0] = '{0, 16'h0100, 16'h0200, 4, 16};
    vecs[1] = '{3, 16'hFFFE, 16'h0010, 4, 16};
    vecs[2] = '{1, 16'h0300, 16'h0310, 1, 4};
    vecs[3] = '{2, 16'h0400, 16'h0500, 0, 0};
    vecs[4] = '{0, 16'h0600, 16'h0602, 5, 20};
    vecs[5] = '{1, 16'h0652, 16'h0650, 3, 12};
    for (int v = 0; v < 6; v++)
      run_single($sformatf("vec%0d", v), vecs[v].ch, vecs[v].src, vecs[v].dst, vecs[v].len, 4'b1111,
                 vecs[v].exp_lat, -1);

    run_single("stall", 1, 16'h1100, 16'h1200, 2, 4'b1001, model_latency(2, 4'b1001), -1);
    run_single("busy_cfg", 0, 16'h0B00, 16'h0C00, 6, 4'b1111, 24, 5);
    run_single("busy_cfg_end", 3, 16'h0D00, 16'h0E00, 6, 4'b1111, 24, 23);

    begin : interleave
      int wr0, d1, d2, cyc, bad;
      logic [15:0] exp_ord [6];
      exp_ord[0] = 16'h0700; exp_ord[1] = 16'h0800; exp_ord[2] = 16'h0701;
      exp_ord[3] = 16'h0801; exp_ord[4] = 16'h0702; exp_ord[5] = 16'h0802;
      reset = 1'b1; tick(); reset = 1'b0;
      wr0 = wr_cnt; d1 = done_cnt[1]; d2 = done_cnt[2];
      cfg_valid = 1'b1; cfg_ch = 1; cfg_src = 16'h0900; cfg_dst = 16'h0700; cfg_len = 3;
      tick();
      cfg_ch = 2; cfg_src = 16'h0A00; cfg_dst = 16'h0800; cfg_len = 3;
      #1 check("ileave cfg_ready_other", cfg_ready, 1);
      tick();
      cfg_valid = 1'b0;
      cyc = 0;
      while (cyc < 200 && !(done_cnt[1] != d1 && done_cnt[2] != d2)) begin
        tick();
        cyc++;
      end
      repeat (2) tick();
      check("ileave done1", done_cnt[1] - d1, 1);
      check("ileave done2", done_cnt[2] - d2, 1);
      check("ileave writes", wr_cnt - wr0, 6);
      bad = 0;
      for (int i = 0; i < 6; i++) if (wr_log[(wr0 + i) % 1024] !== exp_ord[i]) bad++;
      check("ileave order", bad, 0);
      ref_copy(16'h0900, 16'h0700, 3);
      ref_copy(16'h0A00, 16'h0800, 3);
      check_data("ileave ch1", 16'h0700, 3);
      check_data("ileave ch2", 16'h0800, 3);
    end

    begin : reset_mid
      int rd0, wr0, dn0;
      rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt[0];
      cfg_valid = 1'b1; cfg_ch = 0; cfg_src = 16'h0F00; cfg_dst = 16'h0F80; cfg_len = 5; mem_free = 1'b1;
      tick();
      cfg_valid = 1'b0;
      repeat (6) tick();
      reset = 1'b1;
      tick();
      check("rst_mid busy", busy, 0);
      check("rst_mid done", done, 0);
      check("rst_mid mem_req", mem_req, 0);
      reset = 1'b0;
      repeat (8) tick();
      check("rst_mid writes", wr_cnt - wr0, 1);
      check("rst_mid reads", rd_cnt - rd0, 2);
      check("rst_mid no_done", done_cnt[0] - dn0, 0);
      check("rst_mid waddr", wr_log[wr0 % 1024], 16'h0F80);
      ref_copy(16'h0F00, 16'h0F80, 1);
      check_data("rst_mid", 16'h0F80, 1);
    end
    run_single("post_reset", 0, 16'h0F00, 16'h0F90, 3, 4'b1111, 12, -1);

    for (int r = 0; r < 4; r++) begin : rand_stall
      logic [3:0] pat;
      int n;
      pat = 4'($urandom_range(1, 15));
      n = $urandom_range(1, 4);
      run_single($sformatf("rstall%0d", r), $urandom_range(0, NUM_CH - 1), 16'(16'h3000 + r * 64),
                 16'(16'h3800 + r * 64), n, pat, model_latency(n, pat), -1);
    end

    for (int round = 0; round < 3; round++) begin : rand_multi
      int lens [NUM_CH];
      logic [15:0] ss [NUM_CH];
      logic [15:0] dd [NUM_CH];
      int dn0 [NUM_CH];
      int v0, nissued, cyc, start, c, all;
      for (int k = 0; k < NUM_CH; k++) begin
        lens[k] = $urandom_range(0, 6);
        ss[k] = 16'(16'h4000 + round * 16'h400 + k * 64 + $urandom_range(0, 15));
        dd[k] = 16'(16'h6000 + round * 16'h400 + k * 64 + $urandom_range(0, 15));
        dn0[k] = done_cnt[k];
      end
      v0 = viol; nissued = 0; cyc = 0; start = $urandom_range(0, NUM_CH - 1);
      while (cyc < 2000) begin
        mem_free = ($urandom_range(0, 3) != 0);
        cfg_valid = 1'b0;
        if (nissued < NUM_CH && $urandom_range(0, 1) == 1) begin
          c = (start + nissued) % NUM_CH;
          cfg_valid = 1'b1; cfg_ch = CH_W'(c); cfg_src = ss[c]; cfg_dst = dd[c]; cfg_len = LEN_W'(lens[c]);
          #1 check($sformatf("rmulti%0d cfg_ready", round), cfg_ready, 1);
          nissued++;
        end
        tick();
        cyc++;
        all = (nissued == NUM_CH);
        for (int k = 0; k < NUM_CH; k++) if (done_cnt[k] == dn0[k] && !done[k]) all = 0;
        if (all != 0) break;
      end
      cfg_valid = 1'b0; mem_free = 1'b1;
      repeat (2) tick();
      check($sformatf("rmulti%0d in_budget", round), (cyc < 2000), 1);
      check($sformatf("rmulti%0d busy", round), busy, 0);
      check($sformatf("rmulti%0d req_when_busy", round), viol - v0, 0);
      for (int k = 0; k < NUM_CH; k++) begin
        check($sformatf("rmulti%0d done%0d", round, k), done_cnt[k] - dn0[k], 1);
        ref_copy(ss[k], dd[k], lens[k]);
        check_data($sformatf("rmulti%0d ch%0d", round, k), dd[k], lens[k]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dma_multi_channel.md
Name: dma_multi_channel

Overview:
Parametrised multi-channel memory-to-memory DMA engine that shares the single-port SRAM with the CPU controller.
- Cycle-steals only on cycles where the CPU signals the SRAM is free.
- Moves one word at a time: read, capture, write.
- Interleaves active channels at word granularity under round-robin arbitration.
- Successor to the single-channel fixed-width DMA embedded in the controller; programmed through a simple valid/ready config port.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CH_W, 2, channel index width, equal to clog2(NUM_CH), minimum 1
ADDR_W, 16, SRAM word-address width
DATA_W, 32, SRAM data width
LEN_W, 16, transfer-length counter width (words)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cfg_valid  in  1  config request
cfg_ch  in  CH_W  target channel
cfg_src  in  ADDR_W  source start address
cfg_dst  in  ADDR_W  destination start address
cfg_len  in  LEN_W  words to copy
cfg_ready  out  1  combinational: !busy[cfg_ch]
busy  out  NUM_CH  per-channel transfer pending
done  out  NUM_CH  one-cycle completion pulse per channel
mem_free  in  1  CPU does not use SRAM this cycle (combinational from CPU state)
mem_req  out  1  DMA drives SRAM this cycle
mem_addr  out  ADDR_W  SRAM address when mem_req
mem_we  out  1  SRAM write enable (only with mem_req)
mem_di  out  DATA_W  SRAM write data
mem_do  in  DATA_W  SRAM read data, valid the cycle after the address cycle

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values:
  - busy = 0, done = 0, state IDLE, round-robin pointer 0.
  - All channel src/dst/len registers 0; data register 0.
  - mem_req = 0, mem_we = 0.
- Reset mid-transfer abandons the in-flight word with no done pulse.
- Config:
  - Accepted on a clk edge with cfg_valid && cfg_ready: loads src, dst and remaining length.
  - If cfg_len != 0, sets busy[cfg_ch].
  - If cfg_len == 0, busy stays 0 and done[cfg_ch] pulses the next cycle.
  - Config to a busy channel is ignored (cfg_ready = 0), including when that channel completes on the same cycle.
  - Config to an idle channel is accepted while another channel is transferring.
- FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE:
  - If any busy bit is set, select the first busy channel at or after the pointer (wrapping); go READ.
  - A channel configured this cycle is not eligible until the next cycle.
- READ:
  - mem_req = mem_free, mem_we = 0, mem_addr = src[sel].
  - If mem_free, go CAPTURE; otherwise hold in READ.
- CAPTURE:
  - No SRAM access (mem_req = 0).
  - data <= mem_do; go WRITE.
- WRITE:
  - mem_req = mem_free, mem_we = mem_free, mem_addr = dst[sel], mem_di = data.
  - If mem_free: src++, dst++, len-- (addresses wrap mod 2^ADDR_W); pointer <= sel+1 mod NUM_CH; go IDLE.
  - If the new len is 0: clear busy[sel] and pulse done[sel] for the next cycle.
- mem_addr, mem_we and mem_req are combinational from state and mem_free. mem_di is registered data.
- All outputs are 0 in IDLE/CAPTURE.
- Throughput: 4 cycles/word with mem_free held high (IDLE, READ, CAPTURE, WRITE).
  - A stall of k non-free cycles in READ or WRITE adds exactly k cycles.
- Overlapping src/dst ranges copy forward word by word. No hazard protection.
- Length 2^LEN_W-1 is the maximum; there is no length-overflow handling.

Test Plan:
- Ch0, src=0x100, dst=0x200, len=4, mem_free=1 -> mem[0x200..0x203] equals mem[0x100..0x103]; done[0] pulses once, 16 cycles after config; busy[0] falls on the same cycle.
- Ch1 and ch2 each len=3, configured on the same word boundary with mem_free=1 -> writes alternate ch1,ch2,ch1,ch2,ch1,ch2; both done pulses occur.
- mem_free toggles 1,0,0,1 repeatedly during a len=2 copy -> mem_req is never high while mem_free=0; data is correct; completion is delayed exactly by the stall count.
- Config ch0 while busy[0]=1 -> cfg_ready=0 and the original transfer finishes unaltered. Config with len=0 -> done pulses the next cycle and busy stays 0.
- src=0xFFFE, dst=0x0010, len=4 (ADDR_W=16) -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001; writes 0x10..0x13.
- Reset asserted during CAPTURE of word 2 of 5 -> busy=0, no done, mem_req=0 next cycle; a new config after reset runs normally.
